// File: rtl/csa_stream_pkg.sv
// Shared types and elaboration helpers for the carry-save stream accumulator.
package csa_stream_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Number of carry-propagate cycles needed to resolve a WIDTH-bit pair.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal geometry: at least 2 bits, and the chunks tile the word exactly.
  function automatic bit chunk_ok(input int width, input int chunk);
    return (width >= 2) && (chunk > 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/csa_3to2_row.sv
// One 3:2 compressor row: a per-bit full adder, sum and majority outputs.
// co is left unshifted; the caller aligns it to the next bit position.
module csa_3to2_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] co
);

  // Independent XOR/majority per bit so each maps to a single full adder.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]  = a[i] ^ b[i] ^ c[i];
    assign co[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

endmodule

// File: rtl/csa_stream_accum.sv
// Streaming packet summer: carry-save fold per accepted beat, then a
// chunk-serial carry-propagate resolve, then hold the result until taken.
module csa_stream_accum
  import csa_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("csa_stream_accum: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q, state_n;
  logic [WIDTH-1:0] sum_q, carry_q, res_q;
  logic [WIDTH-1:0] row_s, row_co;
  logic [CNT_W-1:0] cnt_q;
  logic [KW-1:0]    k_q;
  logic             rc_q;
  logic             accept, last_k;
  logic [CHUNK-1:0] sum_c, carry_c;
  logic [CHUNK:0]   cpa;

  csa_3to2_row #(.WIDTH(WIDTH)) u_row (
    .a  (sum_q),
    .b  (carry_q),
    .c  (in_data),
    .s  (row_s),
    .co (row_co)
  );

  assign accept    = in_valid & in_ready;
  assign last_k    = (k_q == KW'(NCHUNK - 1));
  assign out_sum   = res_q;
  assign out_count = cnt_q;

  // Select the chunk currently being resolved from the carry-save pair.
  always_comb begin
    sum_c   = '0;
    carry_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        sum_c   = sum_q[i*CHUNK +: CHUNK];
        carry_c = carry_q[i*CHUNK +: CHUNK];
      end
    end
    cpa = {1'b0, sum_c} + {1'b0, carry_c} + {{CHUNK{1'b0}}, rc_q};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_n = RESOLVE;
      RESOLVE: if (last_k)            state_n = DONE;
      DONE:    if (out_ready)         state_n = ACCUM;
      default:                        state_n = ACCUM;
    endcase
  end

  // Handshake outputs depend on state only, so in_ready never sees in_valid.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
  end

  // Datapath: fold beats, resolve chunk by chunk, clear on result handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      rc_q    <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            sum_q   <= row_s;
            carry_q <= {row_co[WIDTH-2:0], 1'b0};
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (in_last) begin
              k_q  <= '0;
              rc_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) res_q[i*CHUNK +: CHUNK] <= cpa[CHUNK-1:0];
          end
          rc_q <= cpa[CHUNK];
          k_q  <= k_q + KW'(1);
        end
        DONE: begin
          if (out_ready) begin
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accum.sv
// Bench for csa_stream_accum: three geometries share clock and reset;
// expected results are queued when a packet is sent and popped on output.
module tb_csa_stream_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld[3], lst[3], ordy[3];
  logic [31:0] a_din;
  logic [7:0]  b_din;
  logic [15:0] c_din;
  logic        rdy[3], ov[3];
  logic [31:0] a_sum;
  logic [7:0]  b_sum;
  logic [15:0] c_sum;
  logic [7:0]  a_cnt, b_cnt;
  logic [1:0]  c_cnt;
  logic [31:0] sum_v[3];
  logic [7:0]  cnt_v[3];

  assign sum_v[0] = a_sum;
  assign sum_v[1] = {24'h0, b_sum};
  assign sum_v[2] = {16'h0, c_sum};
  assign cnt_v[0] = a_cnt;
  assign cnt_v[1] = b_cnt;
  assign cnt_v[2] = {6'h0, c_cnt};

  csa_stream_accum #(.WIDTH(32), .CHUNK(8), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(a_din), .in_last(lst[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_sum(a_sum), .out_count(a_cnt));

  csa_stream_accum #(.WIDTH(8), .CHUNK(4), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(b_din), .in_last(lst[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_sum(b_sum), .out_count(b_cnt));

  csa_stream_accum #(.WIDTH(16), .CHUNK(16), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(c_din), .in_last(lst[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_sum(c_sum), .out_count(c_cnt));

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pkt[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic int nch(input int id);
    return (id == 0) ? 4 : (id == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] wmask(input int id);
    return (id == 0) ? 32'hFFFF_FFFF : (id == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  function automatic logic [7:0] cmax(input int id);
    return (id == 2) ? 8'd3 : 8'd255;
  endfunction

  task automatic drive(input int id, input logic [31:0] d, input logic l);
    case (id)
      0:       a_din = d;
      1:       b_din = d[7:0];
      default: c_din = d[15:0];
    endcase
    vld[id] = 1'b1;
    lst[id] = l;
  endtask

  // Send the words in pkt as one packet; queue the model's expected result.
  task automatic send_pkt(input int id);
    exp_t e;
    int   w;
    e.id  = id;
    e.sum = '0;
    e.cnt = '0;
    for (int i = 0; i < pkt.size(); i++) begin
      e.sum = (e.sum + pkt[i]) & wmask(id);
      if (e.cnt < cmax(id)) e.cnt = e.cnt + 8'd1;
    end
    exp_q.push_back(e);
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      w = 0;
      while (!rdy[id] && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!rdy[id]) begin
        n_cmp++; n_err++;
        $display("FAIL send_ready dut%0d: in_ready=%b required 1", id, rdy[id]);
      end
      drive(id, pkt[i], (i == pkt.size() - 1));
      @(posedge clk);
      #1;
      vld[id] = 1'b0;
      lst[id] = 1'b0;
    end
  endtask

  // Called right after the last-beat accept edge: checks latency, optional
  // hold period, result against the scoreboard, and the handoff.
  task automatic collect(input int id, input int hold);
    int          cyc;
    exp_t        e;
    logic [31:0] s0;
    cyc = 0;
    while (!ov[id] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== nch(id) || ov[id] !== 1'b1) begin
      n_err++;
      $display("FAIL latency dut%0d: got %0d cycles (out_valid=%b) required %0d",
               id, cyc, ov[id], nch(id));
    end
    s0 = sum_v[id];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (ov[id] !== 1'b1 || sum_v[id] !== s0 || rdy[id] !== 1'b0) begin
        n_err++;
        $display("FAIL hold dut%0d cyc%0d: valid=%b sum=%h ready=%b required 1/%h/0",
                 id, h, ov[id], sum_v[id], rdy[id], s0);
      end
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard dut%0d: got empty queue required an entry", id);
    end else begin
      e = exp_q.pop_front();
      if (e.id !== id || sum_v[id] !== e.sum || cnt_v[id] !== e.cnt) begin
        n_err++;
        $display("FAIL result dut%0d: sum=%h count=%0d required sum=%h count=%0d",
                 id, sum_v[id], cnt_v[id], e.sum, e.cnt);
      end
    end
    ordy[id] = 1'b1;
    @(posedge clk);
    #1;
    ordy[id] = 1'b0;
    n_cmp++;
    if (ov[id] !== 1'b0 || rdy[id] !== 1'b1) begin
      n_err++;
      $display("FAIL handoff dut%0d: valid=%b ready=%b required 0/1", id, ov[id], rdy[id]);
    end
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdy[i] !== 1'b1 || ov[i] !== 1'b0 || sum_v[i] !== 32'h0 || cnt_v[i] !== 8'h0) begin
        n_err++;
        $display("FAIL reset dut%0d: ready=%b valid=%b sum=%h count=%0d required 1/0/0/0",
                 i, rdy[i], ov[i], sum_v[i], cnt_v[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    pkt = '{32'd1, 32'd2, 32'd3};
    send_pkt(0);
    collect(0, 0);
  endtask

  task automatic test_wrap();
    pkt = '{32'hC8, 32'h64};
    send_pkt(1);
    collect(1, 0);
    pkt = '{32'hFF, 32'h01};
    send_pkt(1);
    collect(1, 0);
  endtask

  task automatic test_single_beat();
    pkt = '{32'hDEAD_BEEF};
    send_pkt(0);
    collect(0, 0);
  endtask

  task automatic test_hold();
    pkt = '{32'd3, 32'd4};
    send_pkt(0);
    collect(0, 10);
    pkt = '{32'd5};
    send_pkt(0);
    collect(0, 0);
  endtask

  task automatic test_saturate();
    pkt = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    send_pkt(2);
    collect(2, 0);
  endtask

  task automatic test_back_to_back();
    pkt = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h8000_0000, 32'h8000_0001};
    send_pkt(0);
    collect(0, 0);
    pkt = '{32'h1234_5678, 32'h1111_1111};
    send_pkt(0);
    collect(0, 0);
  endtask

  task automatic test_reset_mid_resolve();
    exp_t e;
    pkt = '{32'd9, 32'd4};
    send_pkt(0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b1 || ov[0] !== 1'b0 || sum_v[0] !== 32'h0 || cnt_v[0] !== 8'h0) begin
      n_err++;
      $display("FAIL mid_reset: ready=%b valid=%b sum=%h count=%0d required 1/0/0/0",
               rdy[0], ov[0], sum_v[0], cnt_v[0]);
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    pkt = '{32'd5, 32'd7};
    send_pkt(0);
    collect(0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i]  = 1'b0;
      lst[i]  = 1'b0;
      ordy[i] = 1'b0;
    end
    a_din = '0;
    b_din = '0;
    c_din = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_single_beat();
    test_hold();
    test_saturate();
    test_back_to_back();
    test_reset_mid_resolve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
